// File: rtl/cursor_sprite_gen_pkg.sv
// Shared constants for the bitmap cursor: default sprite size, index widths and the arrow mask.
package cursor_sprite_gen_pkg;

    localparam int SPR_W_DEF = 8;
    localparam int SPR_H_DEF = 12;
    localparam int IDX_W     = 4;
    localparam int MASK_DIM  = 16;

    // One row of the arrow bitmap; bit c is the pixel in column c.
    function automatic logic [MASK_DIM-1:0] mask_row(input logic [IDX_W-1:0] row);
        case (row)
            4'd0:    mask_row = 16'h0001;
            4'd1:    mask_row = 16'h0003;
            4'd2:    mask_row = 16'h0007;
            4'd3:    mask_row = 16'h000F;
            4'd4:    mask_row = 16'h001F;
            4'd5:    mask_row = 16'h003F;
            4'd6:    mask_row = 16'h007F;
            4'd7:    mask_row = 16'h00FF;
            4'd8:    mask_row = 16'h001F;
            4'd9:    mask_row = 16'h001B;
            4'd10:   mask_row = 16'h0031;
            4'd11:   mask_row = 16'h0030;
            default: mask_row = 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/cursor_sprite_gen_mask_rom.sv
// Combinational (row, col) -> opaque-bit lookup of the cursor arrow mask; the caller registers it.
module cursor_mask_rom
    import cursor_sprite_gen_pkg::*;
(
    input  logic [IDX_W-1:0] row_i,
    input  logic [IDX_W-1:0] col_i,
    output logic             bit_o
);

    logic [MASK_DIM-1:0] row_bits;

    always_comb begin
        row_bits = mask_row(row_i);
        bit_o    = row_bits[col_i];
    end

endmodule

// File: rtl/cursor_sprite_gen.sv
// Bitmap cursor overlay: double-buffered position committed at frame start, 2-stage hit pipeline.
// Optional blink of the cursor every BLINK_FRAMES frames when CURSOR_BLINK_EN is defined.
module cursor_sprite_gen
    import cursor_sprite_gen_pkg::*;
#(
    parameter int H_BITS       = 10,
    parameter int V_BITS       = 10,
    parameter int SPR_W        = SPR_W_DEF,
    parameter int SPR_H        = SPR_H_DEF,
    parameter int BLINK_FRAMES = 30
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [H_BITS-1:0] pos_x,
    input  logic [V_BITS-1:0] pos_y,
    input  logic              pos_valid,
    output logic              pos_ready,
    input  logic              frame_start,
    input  logic [H_BITS-1:0] pix_x,
    input  logic [V_BITS-1:0] pix_y,
    input  logic              pix_valid,
    input  logic              cursor_en,
    output logic              out_valid,
    output logic              out_hit,
    output logic [3:0]        out_row,
    output logic [3:0]        out_col
);

    localparam logic signed [H_BITS:0] SPR_W_S = (H_BITS+1)'(SPR_W);
    localparam logic signed [V_BITS:0] SPR_H_S = (V_BITS+1)'(SPR_H);

    logic [H_BITS-1:0] act_x_q, act_x_d, pend_x_q, pend_x_d;
    logic [V_BITS-1:0] act_y_q, act_y_d, pend_y_q, pend_y_d;
    logic              pend_vld_q, pend_vld_d;
    logic              visible;

    assign pos_ready = !pend_vld_q;

    // A pending position can only commit when pend_vld is set, and can only load when it is clear,
    // so a handshake coinciding with frame_start always waits for the next frame.
    always_comb begin
        act_x_d    = act_x_q;
        act_y_d    = act_y_q;
        pend_x_d   = pend_x_q;
        pend_y_d   = pend_y_q;
        pend_vld_d = pend_vld_q;
        if (frame_start && pend_vld_q) begin
            act_x_d    = pend_x_q;
            act_y_d    = pend_y_q;
            pend_vld_d = 1'b0;
        end else if (pos_valid && !pend_vld_q) begin
            pend_x_d   = pos_x;
            pend_y_d   = pos_y;
            pend_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_x_q    <= '0;
            act_y_q    <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            act_x_q    <= act_x_d;
            act_y_q    <= act_y_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        pend_x_q <= pend_x_d;
        pend_y_q <= pend_y_d;
    end

    // Stage 1: sprite-relative offset and box test against the position active this cycle.
    logic signed [H_BITS:0] dx;
    logic signed [V_BITS:0] dy;
    logic                   in_box;
    logic                   vld_p1_q, box_p1_q, en_p1_q;
    logic [IDX_W-1:0]       row_p1_q, col_p1_q;

    assign dx     = $signed({1'b0, pix_x}) - $signed({1'b0, act_x_q});
    assign dy     = $signed({1'b0, pix_y}) - $signed({1'b0, act_y_q});
    assign in_box = !dx[H_BITS] && (dx < SPR_W_S) && !dy[V_BITS] && (dy < SPR_H_S);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
            box_p1_q <= 1'b0;
            en_p1_q  <= 1'b0;
        end else begin
            vld_p1_q <= pix_valid;
            box_p1_q <= pix_valid && in_box;
            en_p1_q  <= cursor_en;
        end
    end

    always_ff @(posedge clk) begin
        row_p1_q <= dy[IDX_W-1:0];
        col_p1_q <= dx[IDX_W-1:0];
    end

    // Stage 2: mask lookup and registered outputs.
    logic mask_bit;
    logic hit_d;
    logic out_valid_q, out_hit_q;
    logic [3:0] out_row_q, out_col_q;

    cursor_mask_rom u_rom (
        .row_i (row_p1_q),
        .col_i (col_p1_q),
        .bit_o (mask_bit)
    );

    assign hit_d = vld_p1_q && box_p1_q && en_p1_q && mask_bit && visible;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_hit_q   <= 1'b0;
            out_row_q   <= '0;
            out_col_q   <= '0;
        end else begin
            out_valid_q <= vld_p1_q;
            out_hit_q   <= hit_d;
            out_row_q   <= hit_d ? row_p1_q : '0;
            out_col_q   <= hit_d ? col_p1_q : '0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_hit   = out_hit_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;

`ifdef CURSOR_BLINK_EN
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [CNT_W-1:0] blink_cnt_q;
    logic             visible_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            visible_q   <= 1'b1;
        end else if (frame_start) begin
            if (blink_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_q <= '0;
                visible_q   <= !visible_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end

    assign visible = visible_q;
`else
    logic unused_blink;
    assign unused_blink = (BLINK_FRAMES > 0);
    assign visible      = 1'b1;
`endif

endmodule

// File: tb/tb_cursor_sprite_gen.sv
// Directed bench for cursor_sprite_gen: per-cycle comparison against a picture-based model plus literal probes.
module tb_cursor_sprite_gen;

    localparam int H_BITS       = 10;
    localparam int V_BITS       = 10;
    localparam int SPR_W        = 8;
    localparam int SPR_H        = 12;
    localparam int BLINK_FRAMES = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [H_BITS-1:0] pos_x = '0;
    logic [V_BITS-1:0] pos_y = '0;
    logic              pos_valid = 1'b0;
    logic              pos_ready;
    logic              frame_start = 1'b0;
    logic [H_BITS-1:0] pix_x = '0;
    logic [V_BITS-1:0] pix_y = '0;
    logic              pix_valid = 1'b0;
    logic              cursor_en = 1'b1;
    logic              out_valid, out_hit;
    logic [3:0]        out_row, out_col;

    always #5 clk = ~clk;

    cursor_sprite_gen #(
        .H_BITS(H_BITS), .V_BITS(V_BITS), .SPR_W(SPR_W), .SPR_H(SPR_H), .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pos_x(pos_x), .pos_y(pos_y), .pos_valid(pos_valid),
        .pos_ready(pos_ready), .frame_start(frame_start), .pix_x(pix_x), .pix_y(pix_y),
        .pix_valid(pix_valid), .cursor_en(cursor_en), .out_valid(out_valid), .out_hit(out_hit),
        .out_row(out_row), .out_col(out_col)
    );

    // The arrow as a picture: 'X' is opaque.
    string art [SPR_H] = '{
        "X.......", "XX......", "XXX.....", "XXXX....", "XXXXX...", "XXXXXX..",
        "XXXXXXX.", "XXXXXXXX", "XXXXX...", "XX.XX...", "X...XX..", "....XX.."
    };

    int   m_ax = 0, m_ay = 0, m_px = 0, m_py = 0, m_cnt = 0;
    bit   m_pend = 0, m_vis = 1;
    logic [9:0] e1 = '0, e2 = '0;
    bit   chk_on = 0;
    int   n_chk = 0, n_pass = 0;

    function automatic logic [9:0] model_eval();
        int dx, dy;
        bit h;
        if (!pix_valid) return 10'b0;
        dx = int'(pix_x) - m_ax;
        dy = int'(pix_y) - m_ay;
        h  = 1'b0;
        if (dx >= 0 && dx < SPR_W && dy >= 0 && dy < SPR_H)
            h = cursor_en && m_vis && (art[dy][dx] == "X");
        return {1'b1, h, h ? 4'(dy) : 4'd0, h ? 4'(dx) : 4'd0};
    endfunction

    always @(posedge clk) begin
        logic [9:0] nxt;
        nxt = model_eval();
        if (!rst_n) begin
            e1 = '0; e2 = '0;
            m_ax = 0; m_ay = 0; m_pend = 0; m_vis = 1; m_cnt = 0;
        end else begin
            e2 = e1;
            e1 = nxt;
            if (frame_start && m_pend) begin
                m_ax = m_px; m_ay = m_py; m_pend = 0;
            end else if (pos_valid && !m_pend) begin
                m_px = int'(pos_x); m_py = int'(pos_y); m_pend = 1;
            end
`ifdef CURSOR_BLINK_EN
            if (frame_start) begin
                if (m_cnt == BLINK_FRAMES - 1) begin m_cnt = 0; m_vis = !m_vis; end
                else m_cnt++;
            end
`endif
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic handshake(input int x, input int y);
        @(negedge clk); pos_x = H_BITS'(x); pos_y = V_BITS'(y); pos_valid = 1'b1;
        @(negedge clk); pos_valid = 1'b0;
    endtask

    task automatic fstart();
        @(negedge clk); frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
    endtask

    // One pixel, then the outputs two cycles later: {valid, hit, row, col}.
    task automatic probe(input string name, input int x, input int y, input bit h, input int r, input int c);
        @(negedge clk); pix_x = H_BITS'(x); pix_y = V_BITS'(y); pix_valid = 1'b1;
        @(negedge clk); pix_valid = 1'b0;
        @(negedge clk);
        check(name, {out_valid, out_hit, out_row, out_col}, {1'b1, h, 4'(r), 4'(c)});
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (chk_on) begin
                    check("pipe", {out_valid, out_hit, out_row, out_col}, e2);
                    check("pos_ready", pos_ready, !m_pend);
                end
            end
        join_none

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset_outs", {out_valid, out_hit, out_row, out_col}, 10'b0);
        check("reset_ready", pos_ready, 1'b1);
        chk_on = 1;

        handshake(100, 50);
        check("ready_after_load", pos_ready, 1'b0);
        fstart();
        check("ready_after_commit", pos_ready, 1'b1);
        probe("origin_hit", 100, 50, 1, 0, 0);
        probe("left_edge", 99, 50, 0, 0, 0);
        probe("right_edge", 108, 50, 0, 0, 0);
        probe("row7_col7", 107, 57, 1, 7, 7);
        probe("row9_col3", 103, 59, 1, 9, 3);
        probe("row9_hole", 102, 59, 0, 0, 0);
        probe("row11_col4", 104, 61, 1, 11, 4);
        probe("below_box", 100, 62, 0, 0, 0);

        handshake(200, 200);
        probe("pend_not_active", 200, 200, 0, 0, 0);
        probe("old_still_active", 100, 50, 1, 0, 0);
        @(negedge clk); pos_x = 10'd1020; pos_y = 10'd0; pos_valid = 1'b1;
        @(negedge clk);
        check("ready_busy", pos_ready, 1'b0);
        pos_valid = 1'b0;
        fstart();
        probe("new_active", 200, 200, 1, 0, 0);
        probe("old_gone", 100, 50, 0, 0, 0);
        probe("no_second_load", 1020, 7, 0, 0, 0);

        handshake(1020, 0);
        fstart();
        probe("edge_col0", 1020, 7, 1, 7, 0);
        probe("edge_col3", 1023, 7, 1, 7, 3);
        probe("no_wrap", 0, 7, 0, 0, 0);
        probe("edge_row0_col1", 1021, 0, 0, 0, 0);
        probe("edge_row0_col0", 1020, 0, 1, 0, 0);

        cursor_en = 1'b0;
        probe("cursor_off", 1020, 7, 0, 0, 0);
        cursor_en = 1'b1;

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            pix_x = H_BITS'(1016 + i);
            pix_y = 10'd7;
            pix_valid = ((i % 3) != 1);
            cursor_en = (i != 6);
        end
        @(negedge clk); pix_valid = 1'b0; cursor_en = 1'b1;
        repeat (3) @(negedge clk);

        handshake(300, 300);
        @(negedge clk); pix_x = 10'd1020; pix_y = 10'd7; pix_valid = 1'b1;
        @(negedge clk); pix_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        check("midreset_outs", {out_valid, out_hit, out_row, out_col}, 10'b0);
        check("midreset_ready", pos_ready, 1'b1);
        rst_n = 1'b1;
        fstart();
        probe("after_reset_origin", 0, 0, 1, 0, 0);
        probe("after_reset_old", 1020, 7, 0, 0, 0);
        probe("flushed_pend", 300, 300, 0, 0, 0);

        repeat (3) @(negedge clk);
        chk_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
